// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: entry type encodings and default index width.
// Imported by the instruction unit and the LSB as well as the ROB itself.
package reorder_buffer_pkg;

    localparam int unsigned ROB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'b00,
        ROB_TYPE_STORE  = 2'b01,
        ROB_TYPE_BRANCH = 2'b10
    } rob_type_e;

endpackage

// File: rtl/rob_query_port.sv
// Operand lookup into the reorder buffer with same-cycle CDB bypass.
// Purely combinational; instantiated once per operand read port.
module rob_query_port #(
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic [(1 << ROB_WIDTH)-1:0]       entryValid,
    input  logic [(1 << ROB_WIDTH)-1:0]       entryReady,
    input  logic [(1 << ROB_WIDTH)-1:0][31:0] entryValue,
    input  logic [ROB_WIDTH-1:0]              qryId,
    input  logic                              cdbValid,
    input  logic [ROB_WIDTH-1:0]              cdbId,
    input  logic [31:0]                       cdbValue,
    output logic                              qryReady,
    output logic [31:0]                       qryValue
);

    logic hit;

    always_comb begin
        hit      = cdbValid && (cdbId == qryId);
        qryReady = entryValid[qryId] && (entryReady[qryId] || hit);
        qryValue = hit ? cdbValue : entryValue[qryId];
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates on issue, completes from the CDB,
// retires one entry per cycle and flushes the pipeline on a branch mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueRd,
    input  logic                 issuePredTaken,
    output logic [ROB_WIDTH-1:0] issueId,
    output logic                 full,
    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbId,
    input  logic [31:0]          cdbValue,
    input  logic                 cdbJump,
    input  logic [31:0]          cdbTarget,
    input  logic [ROB_WIDTH-1:0] qry1Id,
    input  logic [ROB_WIDTH-1:0] qry2Id,
    output logic                 qry1Ready,
    output logic                 qry2Ready,
    output logic [31:0]          qry1Value,
    output logic [31:0]          qry2Value,
    output logic                 writeFlag,
    output logic [ROB_WIDTH-1:0] robId,
    output logic [4:0]           writeAddr,
    output logic [31:0]          writeValue,
    output logic                 storeCommit,
    output logic                 clearOut,
    output logic [31:0]          redirectPc
);

    localparam int unsigned DEPTH = 1 << ROB_WIDTH;
    localparam int unsigned CNT_W = ROB_WIDTH + 1;

    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       ready_q;
    logic [DEPTH-1:0][31:0] value_q;
    logic [1:0]             type_q   [DEPTH];
    logic [4:0]             rd_q     [DEPTH];
    logic                   pred_q   [DEPTH];
    logic                   jump_q   [DEPTH];
    logic [31:0]            target_q [DEPTH];

    logic [ROB_WIDTH-1:0] head_q;
    logic [ROB_WIDTH-1:0] tail_q;
    logic [CNT_W-1:0]     count_q;

    logic       issue_fire;
    logic       commit_fire;
    logic       cdb_fire;
    logic       mispredict;
    logic [1:0] head_type;

    always_comb begin
        issueId     = tail_q;
        full        = (count_q == CNT_W'(DEPTH));
        issue_fire  = readyIn && issueValid && !full;
        head_type   = type_q[head_q];
        commit_fire = readyIn && valid_q[head_q] && ready_q[head_q];
        mispredict  = commit_fire && (head_type == ROB_TYPE_BRANCH)
                      && (jump_q[head_q] != pred_q[head_q]);
        cdb_fire    = readyIn && cdbValid && valid_q[cdbId];
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            valid_q     <= '0;
            ready_q     <= '0;
            value_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            writeFlag   <= 1'b0;
            robId       <= '0;
            writeAddr   <= '0;
            writeValue  <= '0;
            storeCommit <= 1'b0;
            clearOut    <= 1'b0;
            redirectPc  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i]   <= '0;
                rd_q[i]     <= '0;
                pred_q[i]   <= 1'b0;
                jump_q[i]   <= 1'b0;
                target_q[i] <= '0;
            end
        end else begin
            // Retirement outputs are single-cycle pulses; idle cycles drive zero.
            writeFlag   <= commit_fire && (head_type != ROB_TYPE_STORE);
            storeCommit <= commit_fire && (head_type == ROB_TYPE_STORE);
            robId       <= commit_fire ? head_q : '0;
            writeAddr   <= commit_fire ? rd_q[head_q] : '0;
            writeValue  <= commit_fire ? value_q[head_q] : '0;
            clearOut    <= mispredict;
            redirectPc  <= mispredict ? target_q[head_q] : '0;

            if (mispredict) begin
                valid_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (cdb_fire) begin
                    ready_q[cdbId]  <= 1'b1;
                    value_q[cdbId]  <= cdbValue;
                    jump_q[cdbId]   <= cdbJump;
                    target_q[cdbId] <= cdbTarget;
                end
                // Issue after CDB so a completion aimed at a freshly allocated slot loses.
                if (issue_fire) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    type_q[tail_q]  <= issueType;
                    rd_q[tail_q]    <= issueRd;
                    pred_q[tail_q]  <= issuePredTaken;
                    tail_q          <= tail_q + 1'b1;
                end
                if (commit_fire) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + 1'b1;
                end
                if (issue_fire && !commit_fire) begin
                    count_q <= count_q + 1'b1;
                end else if (commit_fire && !issue_fire) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    rob_query_port #(
        .ROB_WIDTH (ROB_WIDTH)
    ) u_query1 (
        .entryValid (valid_q),
        .entryReady (ready_q),
        .entryValue (value_q),
        .qryId      (qry1Id),
        .cdbValid   (cdbValid),
        .cdbId      (cdbId),
        .cdbValue   (cdbValue),
        .qryReady   (qry1Ready),
        .qryValue   (qry1Value)
    );

    rob_query_port #(
        .ROB_WIDTH (ROB_WIDTH)
    ) u_query2 (
        .entryValid (valid_q),
        .entryReady (ready_q),
        .entryValue (value_q),
        .qryId      (qry2Id),
        .cdbValid   (cdbValid),
        .cdbId      (cdbId),
        .cdbValue   (cdbValue),
        .qryReady   (qry2Ready),
        .qryValue   (qry2Value)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// all compared against a program-order queue model of the ROB.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        readyIn = 1'b0;
    logic        issueValid = 1'b0;
    logic [1:0]  issueType = '0;
    logic [4:0]  issueRd = '0;
    logic        issuePredTaken = 1'b0;
    logic [3:0]  issueId;
    logic        full;
    logic        cdbValid = 1'b0;
    logic [3:0]  cdbId = '0;
    logic [31:0] cdbValue = '0;
    logic        cdbJump = 1'b0;
    logic [31:0] cdbTarget = '0;
    logic [3:0]  qry1Id = '0;
    logic [3:0]  qry2Id = '0;
    logic        qry1Ready, qry2Ready;
    logic [31:0] qry1Value, qry2Value;
    logic        writeFlag;
    logic [3:0]  robId;
    logic [4:0]  writeAddr;
    logic [31:0] writeValue;
    logic        storeCommit;
    logic        clearOut;
    logic [31:0] redirectPc;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn        (clockIn),
        .resetIn        (resetIn),
        .readyIn        (readyIn),
        .issueValid     (issueValid),
        .issueType      (issueType),
        .issueRd        (issueRd),
        .issuePredTaken (issuePredTaken),
        .issueId        (issueId),
        .full           (full),
        .cdbValid       (cdbValid),
        .cdbId          (cdbId),
        .cdbValue       (cdbValue),
        .cdbJump        (cdbJump),
        .cdbTarget      (cdbTarget),
        .qry1Id         (qry1Id),
        .qry2Id         (qry2Id),
        .qry1Ready      (qry1Ready),
        .qry2Ready      (qry2Ready),
        .qry1Value      (qry1Value),
        .qry2Value      (qry2Value),
        .writeFlag      (writeFlag),
        .robId          (robId),
        .writeAddr      (writeAddr),
        .writeValue     (writeValue),
        .storeCommit    (storeCommit),
        .clearOut       (clearOut),
        .redirectPc     (redirectPc)
    );

    always #5 clockIn = ~clockIn;

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  typ;
        logic [4:0]  rd;
        bit          pred;
        bit          done;
        logic [31:0] value;
        bit          jump;
        logic [31:0] target;
    } ent_t;

    ent_t m_q[$];
    int   m_tail = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_query(input string tag, input logic [3:0] q, input logic got_r,
                               input logic [31:0] got_v, input bit cv, input logic [3:0] cid,
                               input logic [31:0] cval);
        bit found;
        bit r;
        logic [31:0] v;
        found = 0;
        r = 0;
        v = '0;
        foreach (m_q[i]) begin
            if (m_q[i].id == q) begin
                found = 1;
                r = m_q[i].done || (cv && cid == q);
                v = (cv && cid == q) ? cval : m_q[i].value;
            end
        end
        check_val({tag, "_ready"}, 32'(got_r), 32'(found && r));
        if (found && r) check_val({tag, "_value"}, got_v, v);
    endtask

    task automatic check_regs(input bit wf, input logic [3:0] id, input logic [4:0] wa,
                              input logic [31:0] wv, input bit sc, input bit clr,
                              input logic [31:0] pc);
        check_val("writeFlag", 32'(writeFlag), 32'(wf));
        check_val("robId", 32'(robId), 32'(id));
        check_val("writeAddr", 32'(writeAddr), 32'(wa));
        check_val("writeValue", writeValue, wv);
        check_val("storeCommit", 32'(storeCommit), 32'(sc));
        check_val("clearOut", 32'(clearOut), 32'(clr));
        check_val("redirectPc", redirectPc, pc);
    endtask

    // One clock cycle: drive, check combinational view, advance the model, check commit outputs.
    task automatic step(input bit rdy, input bit iv, input logic [1:0] it, input logic [4:0] ird,
                        input bit ip, input bit cv, input logic [3:0] cid, input logic [31:0] cval,
                        input bit cj, input logic [31:0] ctgt, input logic [3:0] q1,
                        input logic [3:0] q2);
        bit was_full;
        bit e_wf, e_sc, e_clr;
        logic [3:0] e_id;
        logic [4:0] e_wa;
        logic [31:0] e_wv, e_pc;
        ent_t e;
        ent_t n;
        readyIn = rdy; issueValid = iv; issueType = it; issueRd = ird; issuePredTaken = ip;
        cdbValid = cv; cdbId = cid; cdbValue = cval; cdbJump = cj; cdbTarget = ctgt;
        qry1Id = q1; qry2Id = q2;
        #1;
        was_full = (m_q.size() == DEPTH);
        check_val("issueId", 32'(issueId), 32'(m_tail));
        check_val("full", 32'(full), 32'(was_full));
        check_query("qry1", q1, qry1Ready, qry1Value, cv, cid, cval);
        check_query("qry2", q2, qry2Ready, qry2Value, cv, cid, cval);
        e_wf = 0; e_sc = 0; e_clr = 0; e_id = '0; e_wa = '0; e_wv = '0; e_pc = '0;
        if (rdy) begin
            if (m_q.size() > 0 && m_q[0].done) begin
                e = m_q.pop_front();
                e_wf = (e.typ != ROB_TYPE_STORE);
                e_sc = (e.typ == ROB_TYPE_STORE);
                e_id = e.id; e_wa = e.rd; e_wv = e.value;
                e_clr = (e.typ == ROB_TYPE_BRANCH) && (e.jump != e.pred);
                if (e_clr) e_pc = e.target;
            end
            if (e_clr) begin
                m_q.delete();
                m_tail = 0;
            end else begin
                if (cv) begin
                    foreach (m_q[i]) begin
                        if (m_q[i].id == cid) begin
                            m_q[i].done = 1; m_q[i].value = cval;
                            m_q[i].jump = cj; m_q[i].target = ctgt;
                        end
                    end
                end
                if (iv && !was_full) begin
                    n.id = 4'(m_tail); n.typ = it; n.rd = ird; n.pred = ip; n.done = 0;
                    n.value = '0; n.jump = 0; n.target = '0;
                    m_q.push_back(n);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
        @(posedge clockIn);
        @(negedge clockIn);
        check_regs(e_wf, e_id, e_wa, e_wv, e_sc, e_clr, e_pc);
    endtask

    task automatic idle();
        step(1, 0, 2'b00, 5'd0, 0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd0, 4'd0);
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input bit p);
        step(1, 1, t, rd, p, 0, 4'd0, 32'd0, 0, 32'd0, 4'd0, 4'd0);
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] v, input bit j,
                       input logic [31:0] t);
        step(1, 0, 2'b00, 5'd0, 0, 1, id, v, j, t, id, 4'd0);
    endtask

    task automatic do_reset();
        readyIn = 0; issueValid = 0; cdbValid = 0; qry1Id = '0; qry2Id = 4'd1;
        #1;
        resetIn = 0;
        #1;
        check_regs(0, 4'd0, 5'd0, 32'd0, 0, 0, 32'd0);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_qry1Ready", 32'(qry1Ready), 32'd0);
        check_val("rst_qry2Ready", 32'(qry2Ready), 32'd0);
        @(posedge clockIn);
        @(negedge clockIn);
        resetIn = 1;
        m_q.delete();
        m_tail = 0;
        #1;
        check_val("rst_issueId", 32'(issueId), 32'd0);
    endtask

    bit          r_rdy, r_iv, r_ip, r_cv, r_cj;
    logic [1:0]  r_it;
    logic [4:0]  r_rd;
    logic [3:0]  r_cid, r_q1, r_q2;
    logic [31:0] r_cval, r_ctgt;
    int          r_sel, r_idx;

    initial begin
        @(negedge clockIn);
        do_reset();

        // Reset while three entries are live
        issue(ROB_TYPE_REG, 5'd1, 0);
        issue(ROB_TYPE_REG, 5'd2, 0);
        issue(ROB_TYPE_REG, 5'd3, 0);
        do_reset();

        // Out-of-order completion, in-order retirement
        issue(ROB_TYPE_REG, 5'd5, 0);
        issue(ROB_TYPE_REG, 5'd6, 0);
        issue(ROB_TYPE_REG, 5'd7, 0);
        cdb(4'd2, 32'h30, 0, 32'd0);
        cdb(4'd0, 32'h10, 0, 32'd0);
        cdb(4'd1, 32'h20, 0, 32'd0);
        check_val("ooo_c0_value", writeValue, 32'h10);
        idle();
        check_val("ooo_c1_rd", 32'(writeAddr), 32'd6);
        idle();
        check_val("ooo_c2_id", 32'(robId), 32'd2);
        idle();

        // Fill, overflow attempt, partial drain and wrap-around reuse
        do_reset();
        for (int i = 0; i < DEPTH; i++) issue(ROB_TYPE_REG, 5'(i + 1), 0);
        check_val("fill_full", 32'(full), 32'd1);
        issue(ROB_TYPE_REG, 5'd31, 0);
        for (int i = 0; i < 4; i++) cdb(4'(i), 32'(100 + i), 0, 32'd0);
        idle();
        for (int i = 0; i < 4; i++) issue(ROB_TYPE_REG, 5'(20 + i), 0);
        check_val("wrap_full", 32'(full), 32'd1);

        // Branch mispredict flush
        do_reset();
        issue(ROB_TYPE_BRANCH, 5'd0, 0);
        issue(ROB_TYPE_REG, 5'd9, 0);
        cdb(4'd0, 32'h0, 1, 32'h1000);
        idle();
        check_val("mis_clear", 32'(clearOut), 32'd1);
        check_val("mis_pc", redirectPc, 32'h1000);
        cdb(4'd1, 32'h99, 0, 32'd0);
        idle();
        check_val("mis_issueId", 32'(issueId), 32'd0);

        // Store commit
        issue(ROB_TYPE_STORE, 5'd4, 0);
        cdb(4'd0, 32'h55, 0, 32'd0);
        idle();
        check_val("st_commit", 32'(storeCommit), 32'd1);
        check_val("st_noWrite", 32'(writeFlag), 32'd0);

        // Query bypass on a pending entry
        do_reset();
        for (int i = 0; i < 4; i++) issue(ROB_TYPE_REG, 5'(10 + i), 0);
        step(1, 0, 2'b00, 5'd0, 0, 1, 4'd3, 32'hABCD, 0, 32'd0, 4'd3, 4'd2);
        idle();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            r_rdy = ($urandom_range(9) != 0);
            r_iv = ($urandom_range(1) != 0);
            r_sel = $urandom_range(7);
            r_it = (r_sel < 5) ? ROB_TYPE_REG : (r_sel < 6) ? ROB_TYPE_STORE : ROB_TYPE_BRANCH;
            r_rd = 5'($urandom);
            r_ip = ($urandom_range(1) != 0);
            r_cv = ($urandom_range(2) != 0);
            r_cval = $urandom;
            r_ctgt = $urandom;
            if (m_q.size() > 0 && $urandom_range(3) != 0) begin
                r_idx = $urandom_range(m_q.size() - 1);
                r_cid = m_q[r_idx].id;
                r_cj = ($urandom_range(7) == 0) ? !m_q[r_idx].pred : m_q[r_idx].pred;
            end else begin
                r_cid = 4'($urandom);
                r_cj = ($urandom_range(1) != 0);
            end
            r_q1 = ($urandom_range(1) != 0) ? r_cid : 4'($urandom);
            r_q2 = 4'($urandom);
            step(r_rdy, r_iv, r_it, r_rd, r_ip, r_cv, r_cid, r_cval, r_cj, r_ctgt, r_q1, r_q2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order retirement queue between the instruction unit, the common data bus (CDB) and the register file. Allocates one entry per issued instruction and captures results out of order from the CDB. Retires at most one entry per cycle, in program order, driving the register-file write port (writeFlag/robId/writeAddr/writeValue) and the store-commit signal. Detects branch mispredictions at commit and issues the pipeline-wide clear.

## Interface
- ROB_WIDTH, 4: entry-index width; depth = 2^ROB_WIDTH.
- clockIn  in  1  system clock.
- resetIn  in  1  asynchronous, active-low reset.
- readyIn  in  1  global enable; when low, no state changes and commit outputs hold 0.
- issueValid  in  1  allocate an entry this cycle.
- issueType  in  2  entry type: REG, STORE or BRANCH.
- issueRd  in  5  destination register (0 = none).
- issuePredTaken  in  1  predicted direction (BRANCH only).
- issueId  out  ROB_WIDTH  tail index, i.e. the id a same-cycle issue receives.
- full  out  1  count == 2^ROB_WIDTH; issueValid is ignored while high.
- cdbValid  in  1  result broadcast.
- cdbId  in  ROB_WIDTH  entry being completed.
- cdbValue  in  32  rd result.
- cdbJump  in  1  actual direction (BRANCH).
- cdbTarget  in  32  correct next PC (BRANCH).
- qry1Id, qry2Id  in  ROB_WIDTH  operand lookup ids.
- qry1Ready, qry2Ready  out  1  entry value available (combinational).
- qry1Value, qry2Value  out  32  entry value (combinational).
- writeFlag  out  1  register-file write strobe.
- robId  out  ROB_WIDTH  id of the committing entry.
- writeAddr  out  5  committed rd.
- writeValue  out  32  committed value.
- storeCommit  out  1  head STORE retired; the LSB may perform the memory write.
- clearOut  out  1  one-cycle flush pulse.
- redirectPc  out  32  fetch restart PC, valid with clearOut.

## Operation
- Per-entry state: valid, ready, type, rd, predTaken, value, jump, target. Pointers: head, tail (ROB_WIDTH bits, wrap modulo depth). Counter: count (ROB_WIDTH+1 bits).
- Issue: when readyIn, issueValid and !full, write entry[tail] with valid=1 and ready=0, then tail+1.
- CDB: when readyIn and cdbValid, entry[cdbId] gets ready=1, value, jump, target. A CDB write to an invalid entry is ignored.
- Query: qryNReady = entry valid and (ready, or cdbValid and cdbId == qryNId); qryNValue takes cdbValue on that bypass, else the stored value.
- Commit: when readyIn and head entry valid and ready, retire it: head+1, valid=0.
  - writeFlag = (type != STORE), with writeAddr = rd, writeValue = value, robId = head.
  - storeCommit = (type == STORE).
- Mispredict: the committing entry is BRANCH with jump != predTaken.
  - Retire it normally, including its rd write.
  - Also assert clearOut with redirectPc = target.
  - All valid bits clear; head = tail = count = 0; any same-cycle issue or CDB write is discarded.
- Count: +1 on issue, -1 on commit; simultaneous issue and commit leaves it unchanged.

## Timing
- Reset (resetIn low, asynchronous): head = tail = count = 0, all valid = 0, and every registered output = 0 (writeFlag, robId, writeAddr, writeValue, storeCommit, clearOut, redirectPc). qry*Ready = 0. full = 0.
- Commit outputs are registered. The head's ready bit is sampled at a clock edge and the outputs are valid during the following cycle. Each output is a one-cycle pulse per retirement.
- Latency: a CDB write at edge N makes the entry eligible at edge N+1; commit outputs are visible after edge N+1. Issue-to-query-visible: one edge.
- full derives from registered count, so a commit in the full cycle does not admit a same-cycle issue.
- Wrap: tail 2^W-1 -> 0; head follows identically; the full/empty distinction comes from count only.
- clearOut: asserted for exactly one cycle after the mispredict commit edge. The next cycle accepts issue into entry 0.
- readyIn low: the cycle is frozen and registered pulse outputs drop to 0.

## Structure
- Shared package: type encodings ROB_TYPE_REG = 2'b00, ROB_TYPE_STORE = 2'b01, ROB_TYPE_BRANCH = 2'b10; default ROB_WIDTH. Shared with the instruction unit and the LSB.
- Sub-module rob_query_port: combinational lookup plus CDB bypass, instantiated twice. All other logic stays flat.

## Test plan
- Reset: hold resetIn low mid-operation with 3 entries live -> all outputs 0, full = 0, issueId = 0 after release.
- Out-of-order completion: issue REG rd = 5, 6, 7 (ids 0, 1, 2); CDB order 2, 0, 1 with values 0x30, 0x10, 0x20 -> commits id0/rd5/0x10, id1/rd6/0x20, id2/rd7/0x30 on consecutive cycles, starting the cycle after the id1 CDB.
- Full and wrap: issue 16 -> full = 1 and a 17th issue is ignored. Complete and retire ids 0-3, then issue 4 more -> ids 0, 1, 2, 3 reused, and count returns to 16.
- Mispredict: issue BRANCH predTaken = 0 (id0) then REG (id1). CDB id0 with jump = 1, target 0x1000 -> clearOut pulse, redirectPc = 0x1000, id1 never commits, next issueId = 0.
- Store: issue STORE, complete via CDB -> storeCommit = 1 and writeFlag = 0 for one cycle.
- Query bypass: qry1Id = 3 with entry 3 pending and cdbValid, cdbId = 3, cdbValue = 0xABCD in the same cycle -> qry1Ready = 1, qry1Value = 0xABCD.
